mem_stage: RTL and testbench

//  Memory-access pipeline stage between EX and WB. Latches the EX bundle, waits for the data-SRAM

---
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_stage.sv | 82 ++++++++
 tb/tb_mem_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Handshake and data bus between EX, MEM, WB, ID and the data SRAM response port.
// The slave modport is the MEM stage's view of these signals.
interface mem_stage_if;
    localparam int unsigned EsToMsBusWd = 77;
    localparam int unsigned MsToWsBusWd = 70;
    localparam int unsigned MsToDsBusWd = 39;

    logic                   ms_allowin;
    logic                   es_to_ms_valid;
    logic [EsToMsBusWd-1:0] es_to_ms_bus;
    logic                   ws_allowin;
    logic                   ms_to_ws_valid;
    logic [MsToWsBusWd-1:0] ms_to_ws_bus;
    logic [MsToDsBusWd-1:0] ms_to_ds_bus;
    logic                   data_sram_data_ok;
    logic [31:0]            data_sram_rdata;

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
    );

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EX bundle, waits for the data-SRAM response and
// aligns/extends load data. Buffers returned data while WB stalls.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus_if
);
    logic        ms_valid_q;
    logic        pending_q;
    logic        buf_valid_q;
    logic [31:0] data_buf_q;
    logic [76:0] es_bus_q;

    logic        mem_req;
    logic        mem_we;
    logic [2:0]  ld_type;
    logic [1:0]  addr_low;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic        ms_ready_go;
    logic        ms_allowin;
    logic [31:0] load_src;
    logic [31:0] load_shifted;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign {mem_req, mem_we, ld_type, addr_low, gr_we, dest, alu_result, pc} = es_bus_q;

    // data_ok only matters while a request is outstanding.
    assign ms_ready_go = !pending_q || bus_if.data_sram_data_ok;
    assign ms_allowin  = !ms_valid_q || (ms_ready_go && bus_if.ws_allowin);

    assign load_src     = buf_valid_q ? data_buf_q : bus_if.data_sram_rdata;
    assign load_shifted = load_src >> {addr_low, 3'b000};

    always_comb begin
        load_data = load_src;
        unique case (ld_type)
            3'b001:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b010:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b011:  load_data = {24'h0, load_shifted[7:0]};
            3'b100:  load_data = {16'h0, load_shifted[15:0]};
            default: load_data = load_src;
        endcase
    end

    assign final_result = (mem_req && !mem_we) ? load_data : alu_result;

    assign bus_if.ms_allowin     = ms_allowin;
    assign bus_if.ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign bus_if.ms_to_ws_bus   = {gr_we, dest, final_result, pc};
    assign bus_if.ms_to_ds_bus   = {ms_valid_q && gr_we,
                                    ms_valid_q && mem_req && !mem_we && !ms_ready_go,
                                    dest, final_result};

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q  <= 1'b0;
            pending_q   <= 1'b0;
            buf_valid_q <= 1'b0;
            data_buf_q  <= 32'h0;
            es_bus_q    <= 77'h0;
        end else begin
            if (ms_allowin) begin
                ms_valid_q  <= bus_if.es_to_ms_valid;
                buf_valid_q <= 1'b0;
                pending_q   <= bus_if.es_to_ms_valid && bus_if.es_to_ms_bus[76];
                if (bus_if.es_to_ms_valid) begin
                    es_bus_q <= bus_if.es_to_ms_bus;
                end
            end else if (pending_q && bus_if.data_sram_data_ok) begin
                // WB stalled on the response cycle: hold the data until the bundle leaves.
                pending_q   <= 1'b0;
                buf_valid_q <= 1'b1;
                data_buf_q  <= bus_if.data_sram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, load alignment,
// WB stall buffering, store/load back-to-back and reset during a wait.
module tb_mem_stage;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_stage_if bus_if ();

    mem_stage dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [76:0] mk(input logic req, input logic we, input logic [2:0] lt,
                                       input logic [1:0] al, input logic gw, input logic [4:0] d,
                                       input logic [31:0] alu, input logic [31:0] pc);
        return {req, we, lt, al, gw, d, alu, pc};
    endfunction

    task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] al,
                           input logic [31:0] rd, input logic [31:0] exp, input int waits);
        step();
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = mk(1'b1, 1'b0, lt, al, 1'b1, 5'd3, 32'hA5A5A5A5, 32'h1c000100);
        bus_if.ws_allowin     = 1'b1;
        step();
        bus_if.es_to_ms_valid = 1'b0;
        #1;
        for (int i = 0; i < waits; i++) begin
            check({tag, "_wait_valid"}, bus_if.ms_to_ws_valid, 0);
            check({tag, "_wait_block"}, bus_if.ms_to_ds_bus[37], 1);
            step();
        end
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = rd;
        #1;
        check({tag, "_valid"}, bus_if.ms_to_ws_valid, 1);
        check({tag, "_result"}, bus_if.ms_to_ws_bus[63:32], exp);
        check({tag, "_block"}, bus_if.ms_to_ds_bus[37], 0);
        step();
        bus_if.data_sram_data_ok = 1'b0;
        bus_if.data_sram_rdata   = 32'h0;
        #1;
        check({tag, "_exit"}, bus_if.ms_to_ws_valid, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus_if.es_to_ms_valid    = 1'b0;
        bus_if.es_to_ms_bus      = '0;
        bus_if.ws_allowin        = 1'b0;
        bus_if.data_sram_data_ok = 1'b0;
        bus_if.data_sram_rdata   = 32'h0;
        step();
        step();
        check("rst_valid", bus_if.ms_to_ws_valid, 0);
        check("rst_allowin", bus_if.ms_allowin, 1);
        check("rst_ds", bus_if.ms_to_ds_bus[38:37], 0);

        // ALU op passes through with no extra latency.
        reset = 1'b0;
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = mk(1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 5'd5, 32'h12345678, 32'h1c000000);
        bus_if.ws_allowin     = 1'b1;
        #1;
        check("alu_allowin_empty", bus_if.ms_allowin, 1);
        step();
        bus_if.es_to_ms_valid = 1'b0;
        #1;
        check("alu_valid", bus_if.ms_to_ws_valid, 1);
        check("alu_bus", bus_if.ms_to_ws_bus, {1'b1, 5'd5, 32'h12345678, 32'h1c000000});
        check("alu_allowin", bus_if.ms_allowin, 1);
        check("alu_ds", bus_if.ms_to_ds_bus[38:37], 2'b10);
        step();
        check("alu_exit", bus_if.ms_to_ws_valid, 0);

        do_load("ldb",  3'b001, 2'd3, 32'h80FF1234, 32'hFFFFFF80, 1);
        do_load("ldbu", 3'b011, 2'd3, 32'h80FF1234, 32'h00000080, 1);
        do_load("ldh",  3'b010, 2'd2, 32'hBEEF0000, 32'hFFFFBEEF, 0);
        do_load("ldhu", 3'b100, 2'd2, 32'hBEEF0000, 32'h0000BEEF, 0);
        do_load("ldw",  3'b000, 2'd2, 32'hBEEF0000, 32'hBEEF0000, 0);
        do_load("ld101", 3'b101, 2'd1, 32'h11223344, 32'h11223344, 0);
        do_load("ldb1", 3'b001, 2'd1, 32'h00007F00, 32'h0000007F, 0);

        // WB stall on the response cycle: data must be held, later rdata ignored.
        step();
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = mk(1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 5'd8, 32'h0, 32'h1c000200);
        step();
        bus_if.es_to_ms_valid    = 1'b0;
        bus_if.ws_allowin        = 1'b0;
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'hCAFE1234;
        #1;
        check("stall_c0_valid", bus_if.ms_to_ws_valid, 1);
        check("stall_c0_result", bus_if.ms_to_ws_bus[63:32], 32'hCAFE1234);
        check("stall_c0_allowin", bus_if.ms_allowin, 0);
        step();
        bus_if.data_sram_data_ok = 1'b0;
        bus_if.data_sram_rdata   = 32'hDEADDEAD;
        for (int i = 1; i < 3; i++) begin
            #1;
            check("stall_hold_valid", bus_if.ms_to_ws_valid, 1);
            check("stall_hold_result", bus_if.ms_to_ws_bus[63:32], 32'hCAFE1234);
            check("stall_hold_allowin", bus_if.ms_allowin, 0);
            step();
        end
        bus_if.ws_allowin = 1'b1;
        #1;
        check("stall_rel_valid", bus_if.ms_to_ws_valid, 1);
        check("stall_rel_result", bus_if.ms_to_ws_bus[63:32], 32'hCAFE1234);
        check("stall_rel_allowin", bus_if.ms_allowin, 1);
        step();
        check("stall_exit", bus_if.ms_to_ws_valid, 0);

        // Store then load back-to-back.
        bus_if.data_sram_rdata = 32'h0;
        bus_if.es_to_ms_valid  = 1'b1;
        bus_if.es_to_ms_bus    = mk(1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 5'd0, 32'h00000200, 32'h1c000300);
        step();
        bus_if.es_to_ms_bus      = mk(1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 5'd9, 32'h00000204,
                                      32'h1c000304);
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'hFFFFFFFF;
        #1;
        check("st_valid", bus_if.ms_to_ws_valid, 1);
        check("st_bus", bus_if.ms_to_ws_bus, {1'b0, 5'd0, 32'h00000200, 32'h1c000300});
        check("st_allowin", bus_if.ms_allowin, 1);
        step();
        bus_if.es_to_ms_valid    = 1'b0;
        bus_if.data_sram_data_ok = 1'b0;
        #1;
        check("ld2_wait_valid", bus_if.ms_to_ws_valid, 0);
        check("ld2_wait_block", bus_if.ms_to_ds_bus[38:37], 2'b11);
        check("ld2_wait_pc", bus_if.ms_to_ws_bus[31:0], 32'h1c000304);
        step();
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h000055AA;
        #1;
        check("ld2_bus", bus_if.ms_to_ws_bus, {1'b1, 5'd9, 32'h000055AA, 32'h1c000304});
        check("ld2_valid", bus_if.ms_to_ws_valid, 1);
        step();
        bus_if.data_sram_data_ok = 1'b0;
        #1;
        check("ld2_exit", bus_if.ms_to_ws_valid, 0);

        // Reset while waiting, then a stray response.
        bus_if.es_to_ms_valid = 1'b1;
        bus_if.es_to_ms_bus   = mk(1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 5'd4, 32'h0, 32'h1c000400);
        step();
        bus_if.es_to_ms_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rstw_block", bus_if.ms_to_ds_bus[37], 1);
        step();
        reset = 1'b0;
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h12121212;
        #1;
        check("rstw_valid", bus_if.ms_to_ws_valid, 0);
        check("rstw_allowin", bus_if.ms_allowin, 1);
        check("rstw_ds", bus_if.ms_to_ds_bus[38:37], 0);
        step();
        bus_if.data_sram_data_ok = 1'b0;
        #1;
        check("rstw_after_valid", bus_if.ms_to_ws_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
